// File: rtl/mem_access_unit.sv
// MEM stage: variable-latency data bus, byte-lane alignment, load extension, MEM/WB register.
// Optional MEM_ACCESS_MISALIGN_EXC_EN flags misaligned half/word accesses instead of aligning down.
module mem_access_unit #(
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 stall,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_mem_read,
    input  logic                 in_mem_write,
    input  logic [1:0]           in_width,
    input  logic                 in_unsigned,
    input  logic [ADDR_W-1:0]    in_addr,
    input  logic [31:0]          in_wdata,
    input  logic [31:0]          in_alu_data,
    output logic                 busy,
    output logic                 dm_req_valid,
    input  logic                 dm_req_ready,
    output logic [ADDR_W-1:0]    dm_req_addr,
    output logic                 dm_req_we,
    output logic [3:0]           dm_req_be,
    output logic [31:0]          dm_req_wdata,
    input  logic                 dm_resp_valid,
    input  logic [31:0]          dm_resp_rdata,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [31:0]          out_wb_data
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    ,
    output logic                 out_misalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t state, nxt;

    logic [1:0]           r_width;
    logic                 r_uns;
    logic [1:0]           r_off;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [31:0]          r_res;
    logic                 drop;

    logic [1:0]  off_eff;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic        misal;
    logic        is_mem;
    logic        misal_op;
    logic        accept;
    logic        keep;
    logic        done;
    logic [31:0] ld_sh;
    logic [31:0] ld_ext;
    logic [31:0] comp_data;

    assign is_mem   = in_valid & (in_mem_read | in_mem_write);
    assign misal_op = is_mem & misal;
    assign accept   = is_mem & ~flush & ~misal_op;
    // A completing result parks in HOLD only if it is still wanted.
    assign keep     = stall & ~drop & ~flush;
    assign done     = (state == REQ && dm_req_ready && dm_req_we)
                    | (state == WAIT && dm_resp_valid);
    assign comp_data = dm_req_we ? r_res : ld_ext;

    always_comb begin
        off_eff = in_addr[1:0];
        be_n    = 4'hF;
        wd_n    = in_wdata;
        misal   = 1'b0;
        case (in_width)
            2'd0: begin
                be_n = 4'b0001 << off_eff;
                wd_n = {4{in_wdata[7:0]}};
            end
            2'd1: begin
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                misal   = in_addr[0];
`else
                off_eff = {in_addr[1], 1'b0};
`endif
                be_n = 4'b0011 << off_eff;
                wd_n = {2{in_wdata[15:0]}};
            end
            default: begin
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                misal   = |in_addr[1:0];
`else
                off_eff = 2'b00;
`endif
            end
        endcase
    end

    always_comb begin
        ld_sh = dm_resp_rdata >> {r_off, 3'b000};
        case (r_width)
            2'd0:    ld_ext = {{24{~r_uns & ld_sh[7]}}, ld_sh[7:0]};
            2'd1:    ld_ext = {{16{~r_uns & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_ext = ld_sh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) nxt = REQ;
            REQ: begin
                if (dm_req_ready)
                    nxt = dm_req_we ? (keep ? HOLD : IDLE) : WAIT;
            end
            WAIT: if (dm_resp_valid) nxt = keep ? HOLD : IDLE;
            default: if (!stall || flush) nxt = IDLE;
        endcase
    end

    always_comb begin
        dm_req_valid = (state == REQ);
        busy         = (state == IDLE) ? accept : (nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dm_req_addr  <= '0;
            dm_req_we    <= 1'b0;
            dm_req_be    <= 4'h0;
            dm_req_wdata <= '0;
            r_width      <= 2'd0;
            r_uns        <= 1'b0;
            r_off        <= 2'd0;
            r_payload    <= '0;
            r_res        <= '0;
            drop         <= 1'b0;
            out_valid    <= 1'b0;
            out_payload  <= '0;
            out_wb_data  <= '0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
            out_misalign <= 1'b0;
`endif
        end else begin
            if (state == IDLE && accept) begin
                dm_req_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
                dm_req_we    <= in_mem_write;
                dm_req_be    <= be_n;
                dm_req_wdata <= wd_n;
                r_width      <= in_width;
                r_uns        <= in_unsigned;
                r_off        <= off_eff;
                r_payload    <= in_payload;
                r_res        <= in_alu_data;
            end else if (done && keep) begin
                r_res <= comp_data;
            end

            if (nxt == IDLE)
                drop <= 1'b0;
            else if (flush && state != IDLE)
                drop <= 1'b1;

            if (flush) begin
                out_valid   <= 1'b0;
                out_payload <= '0;
                out_wb_data <= '0;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                out_misalign <= 1'b0;
`endif
            end else if (!stall) begin
                case (state)
                    IDLE: begin
                        out_valid   <= in_valid & ~accept;
                        out_payload <= in_payload;
                        out_wb_data <= misal_op ? 32'h0 : in_alu_data;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                        out_misalign <= misal_op;
`endif
                    end
                    REQ, WAIT: begin
                        out_valid   <= done & ~drop;
                        out_payload <= r_payload;
                        out_wb_data <= comp_data;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                        out_misalign <= 1'b0;
`endif
                    end
                    default: begin
                        out_valid   <= 1'b1;
                        out_payload <= r_payload;
                        out_wb_data <= r_res;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                        out_misalign <= 1'b0;
`endif
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table, bus responder model and output scoreboard.
// Also covers MEM_ACCESS_MISALIGN_EXC_EN when that macro is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, stall, in_valid;
    logic [95:0] in_payload;
    logic        in_mem_read, in_mem_write;
    logic [1:0]  in_width;
    logic        in_unsigned;
    logic [31:0] in_addr, in_wdata, in_alu_data;
    logic        busy, dm_req_valid, dm_req_ready, dm_req_we;
    logic [31:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
    logic [3:0]  dm_req_be;
    logic        dm_resp_valid, out_valid;
    logic [95:0] out_payload;
    logic [31:0] out_wb_data;
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
    logic        out_misalign;
`endif

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .PAYLOAD_W(96)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_payload(in_payload),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_width(in_width), .in_unsigned(in_unsigned),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_alu_data(in_alu_data),
        .busy(busy), .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr), .dm_req_we(dm_req_we), .dm_req_be(dm_req_be),
        .dm_req_wdata(dm_req_wdata), .dm_resp_valid(dm_resp_valid),
        .dm_resp_rdata(dm_resp_rdata), .out_valid(out_valid),
        .out_payload(out_payload), .out_wb_data(out_wb_data)
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        , .out_misalign(out_misalign)
`endif
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [95:0] pl;
        logic [31:0] wb;
        logic        mis;
    } exp_t;

    exp_t sbq[$];

    task automatic push_exp(input logic [95:0] pl, input logic [31:0] wb, input logic mis);
        exp_t e;
        e.pl = pl; e.wb = wb; e.mis = mis;
        sbq.push_back(e);
    endtask

    // Output monitor: one MEM/WB entry per edge with out_valid set and no stall/flush.
    logic mon_s, mon_f, mon_r;
    exp_t mon_e;
    always @(posedge clk) begin
        mon_s = stall; mon_f = flush; mon_r = rst;
        #1;
        if (!mon_r && !mon_s && !mon_f && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = sbq.pop_front();
                chk("wb_data", out_wb_data, mon_e.wb);
                chk("payload", out_payload, mon_e.pl);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
                chk("misalign", out_misalign, mon_e.mis);
`endif
            end
        end
    end

    // Data bus responder: ready after rdy_dly cycles, load data resp_lat cycles after handshake.
    int          rdy_dly = 0, resp_lat = 1, req_cnt = 0, pending = 0, hs_cnt = 0;
    logic [31:0] bus_rdata = '0;
    logic        seen = 1'b0, e_chk = 1'b0, e_we = 1'b0, f_we = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, f_addr = '0, f_wdata = '0;
    logic [3:0]  e_be = '0, f_be = '0;

    always @(negedge clk) begin
        if (rst) begin
            dm_req_ready  = 1'b0;
            dm_resp_valid = 1'b0;
            dm_resp_rdata = '0;
            req_cnt = 0; pending = 0; seen = 1'b0;
        end else begin
            dm_resp_valid = 1'b0;
            if (dm_req_ready) begin
                hs_cnt++;
                dm_req_ready = 1'b0;
                req_cnt = 0;
                seen = 1'b0;
                if (!f_we) pending = resp_lat;
            end
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    dm_resp_valid = 1'b1;
                    dm_resp_rdata = bus_rdata;
                end
            end
            if (dm_req_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    f_addr = dm_req_addr; f_be = dm_req_be;
                    f_wdata = dm_req_wdata; f_we = dm_req_we;
                    if (e_chk) begin
                        chk("req_addr", dm_req_addr, e_addr);
                        chk("req_be", dm_req_be, e_be);
                        chk("req_wdata", dm_req_wdata, e_wdata);
                        chk("req_we", dm_req_we, e_we);
                    end
                end else begin
                    chk("req_stable", {dm_req_addr, dm_req_be, dm_req_wdata, dm_req_we},
                        {f_addr, f_be, f_wdata, f_we});
                end
                if (req_cnt == rdy_dly) dm_req_ready = 1'b1;
                else req_cnt++;
            end
        end
    end

    typedef struct {
        logic        rd, wr;
        logic [1:0]  w;
        logic        u;
        logic [31:0] addr, wdata, alu, rdata;
        int          dly, lat;
        logic [31:0] r_addr;
        logic [3:0]  r_be;
        logic [31:0] r_wdata, wb;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] w,
                                input logic u, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] alu, input logic [31:0] rdata,
                                input int dly, input int lat, input logic [31:0] r_addr,
                                input logic [3:0] r_be, input logic [31:0] r_wdata,
                                input logic [31:0] wb);
        vec_t v;
        v.rd = rd; v.wr = wr; v.w = w; v.u = u; v.addr = addr; v.wdata = wdata;
        v.alu = alu; v.rdata = rdata; v.dly = dly; v.lat = lat;
        v.r_addr = r_addr; v.r_be = r_be; v.r_wdata = r_wdata; v.wb = wb;
        return v;
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu,
                         input logic [95:0] pl);
        in_valid = 1'b1; in_mem_read = rd; in_mem_write = wr; in_width = w;
        in_unsigned = u; in_addr = a; in_wdata = wd; in_alu_data = alu; in_payload = pl;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
    endtask

    task automatic set_bus(input int dly, input int lat, input logic [31:0] rdata,
                           input logic c, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic we);
        rdy_dly = dly; resp_lat = lat; bus_rdata = rdata;
        e_chk = c; e_addr = a; e_be = be; e_wdata = wd; e_we = we;
    endtask

    task automatic apply(input vec_t v);
        int          cyc, h0, exp_cyc;
        logic        mem;
        logic [95:0] pl;
        mem = v.rd | v.wr;
        exp_cyc = !mem ? 0 : (v.wr ? 1 + v.dly : 1 + v.dly + v.lat);
        pl = {$urandom, $urandom, $urandom};
        @(negedge clk);
        set_bus(v.dly, v.lat, v.rdata, mem, v.r_addr, v.r_be, v.r_wdata, v.wr);
        h0 = hs_cnt;
        drive(v.rd, v.wr, v.w, v.u, v.addr, v.wdata, v.alu, pl);
        push_exp(pl, v.wb, 1'b0);
        cyc = 0;
        #4;
        while (busy && cyc < 40) begin
            cyc++;
            @(negedge clk);
            #4;
        end
        chk("busy_cycles", cyc, exp_cyc);
        @(negedge clk);
        idle_in();
        #1;
        chk("req_count", hs_cnt - h0, mem ? 1 : 0);
    endtask

    int          h0, n;
    logic        ov;
    logic [31:0] ow;
    logic [95:0] pl;

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0;
        in_valid = 1'b0; in_payload = '0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_width = 2'd0; in_unsigned = 1'b0; in_addr = '0; in_wdata = '0; in_alu_data = '0;
        dm_req_ready = 1'b0; dm_resp_valid = 1'b0; dm_resp_rdata = '0;

        vt.push_back(mk(0,0,2'd0,0,32'h103,32'h0,32'h1234,32'h0,0,1,32'h0,4'h0,32'h0,32'h1234));
        vt.push_back(mk(1,0,2'd0,0,32'h103,32'h11223344,32'h9999,32'h80FFFF00,0,3,32'h100,4'b1000,32'h44444444,32'hFFFFFF80));
        vt.push_back(mk(1,0,2'd0,1,32'h103,32'h11223344,32'h9999,32'h80FFFF00,0,3,32'h100,4'b1000,32'h44444444,32'h00000080));
        vt.push_back(mk(0,1,2'd1,0,32'h202,32'h0000ABCD,32'h55,32'h0,2,1,32'h200,4'b1100,32'hABCDABCD,32'h55));
        vt.push_back(mk(0,1,2'd0,0,32'h001,32'h123456EF,32'h66,32'h0,1,1,32'h0,4'b0010,32'hEFEFEFEF,32'h66));
        vt.push_back(mk(0,1,2'd2,0,32'h010,32'hDEADBEEF,32'h77,32'h0,0,1,32'h10,4'hF,32'hDEADBEEF,32'h77));
        vt.push_back(mk(1,0,2'd1,0,32'h206,32'h0,32'h0,32'h80017FFF,1,2,32'h204,4'b1100,32'h0,32'hFFFF8001));
        vt.push_back(mk(1,0,2'd1,1,32'h204,32'h0,32'h0,32'h80017FFF,0,2,32'h204,4'b0011,32'h0,32'h00007FFF));
        vt.push_back(mk(1,0,2'd2,0,32'h300,32'h01020304,32'h0,32'hCAFEF00D,0,1,32'h300,4'hF,32'h01020304,32'hCAFEF00D));
        vt.push_back(mk(1,0,2'd0,1,32'h002,32'h0,32'h0,32'h00A50000,0,1,32'h0,4'b0100,32'h0,32'h000000A5));
        vt.push_back(mk(1,0,2'd0,0,32'h002,32'h0,32'h0,32'h00A50000,2,2,32'h0,4'b0100,32'h0,32'hFFFFFFA5));
        vt.push_back(mk(1,0,2'd3,0,32'h008,32'h0,32'h0,32'h13579BDF,0,1,32'h8,4'hF,32'h0,32'h13579BDF));
        vt.push_back(mk(1,0,2'd0,0,32'h000,32'h0,32'h0,32'h0000007F,0,1,32'h0,4'b0001,32'h0,32'h0000007F));
        vt.push_back(mk(0,0,2'd0,0,32'h0,32'h0,32'hFFFF0000,32'h0,0,1,32'h0,4'h0,32'h0,32'hFFFF0000));
`ifndef MEM_ACCESS_MISALIGN_EXC_EN
        vt.push_back(mk(1,0,2'd2,0,32'h101,32'h0,32'h0,32'h89ABCDEF,0,1,32'h100,4'hF,32'h0,32'h89ABCDEF));
        vt.push_back(mk(1,0,2'd1,0,32'h203,32'h0,32'h0,32'h80001234,0,2,32'h200,4'b1100,32'h0,32'hFFFF8000));
        vt.push_back(mk(0,1,2'd1,0,32'h001,32'h0000BEEF,32'h88,32'h0,1,1,32'h0,4'b0011,32'hBEEFBEEF,32'h88));
`endif

        repeat (3) @(negedge clk);
        chk("reset_out", {out_valid, out_payload, out_wb_data}, '0);
        chk("reset_bus", {busy, dm_req_valid, dm_req_addr, dm_req_be, dm_req_wdata, dm_req_we}, '0);
`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        chk("reset_misalign", out_misalign, 1'b0);
`endif
        rst = 1'b0;

        foreach (vt[i]) apply(vt[i]);

        // Load whose response lands under stall parks in HOLD.
        @(negedge clk);
        pl = {$urandom, $urandom, $urandom};
        set_bus(0, 2, 32'h11112222, 1'b1, 32'h40, 4'hF, 32'h0, 1'b0);
        h0 = hs_cnt;
        drive(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, pl);
        push_exp(pl, 32'h11112222, 1'b0);
        n = 0;
        #2;
        while (!dm_resp_valid && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        stall = 1'b1;
        #2;
        chk("hold_busy_resp", busy, 1'b1);
        ov = out_valid; ow = out_wb_data;
        repeat (2) begin
            @(negedge clk);
            #4;
            chk("hold_busy", busy, 1'b1);
            chk("hold_out", {out_valid, out_wb_data}, {ov, ow});
        end
        @(negedge clk);
        stall = 1'b0;
        #4;
        chk("hold_release_busy", busy, 1'b0);
        @(negedge clk);
        idle_in();
        #1;
        chk("hold_out_valid", out_valid, 1'b1);
        chk("hold_req_count", hs_cnt - h0, 1);

        // Flush while the load waits for its response.
        @(negedge clk);
        set_bus(0, 4, 32'hDEAD0000, 1'b1, 32'h80, 4'hF, 32'h0, 1'b0);
        h0 = hs_cnt;
        drive(1, 0, 2'd2, 0, 32'h80, 32'h0, 32'h0, {$urandom, $urandom, $urandom});
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("flush_in_wait", dm_req_valid, 1'b0);
        flush = 1'b1;
        idle_in();
        #3;
        chk("flush_busy", busy, 1'b1);
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        #2;
        while (!dm_resp_valid && n < 10) begin
            #2;
            chk("flush_busy_wait", busy, 1'b1);
            @(negedge clk);
            #2;
            n++;
        end
        #2;
        chk("flush_busy_resp", busy, 1'b0);
        @(negedge clk);
        #1;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_req_count", hs_cnt - h0, 1);

        // Flush in the same cycle blocks acceptance of a memory op.
        @(negedge clk);
        e_chk = 1'b0;
        h0 = hs_cnt;
        drive(1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h0, {$urandom, $urandom, $urandom});
        flush = 1'b1;
        #4;
        chk("flush_accept_busy", busy, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        idle_in();
        #1;
        chk("flush_accept_req", dm_req_valid, 1'b0);
        chk("flush_accept_out", out_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("flush_accept_cnt", hs_cnt - h0, 0);

        // Stall and flush together: flush wins.
        @(negedge clk);
        pl = {$urandom, $urandom, $urandom};
        drive(0, 0, 2'd0, 0, 32'h0, 32'h0, 32'hABCD, pl);
        push_exp(pl, 32'hABCD, 1'b0);
        @(negedge clk);
        idle_in();
        stall = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_flush_out", {out_valid, out_wb_data}, '0);
        @(negedge clk);
        stall = 1'b0;
        flush = 1'b0;

`ifdef MEM_ACCESS_MISALIGN_EXC_EN
        @(negedge clk);
        h0 = hs_cnt;
        pl = {$urandom, $urandom, $urandom};
        drive(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h5555, pl);
        push_exp(pl, 32'h0, 1'b1);
        #4;
        chk("misal_lw_busy", busy, 1'b0);
        @(negedge clk);
        pl = {$urandom, $urandom, $urandom};
        drive(0, 1, 2'd1, 0, 32'h203, 32'h0, 32'h6666, pl);
        push_exp(pl, 32'h0, 1'b1);
        #4;
        chk("misal_sh_busy", busy, 1'b0);
        @(negedge clk);
        idle_in();
        #1;
        chk("misal_req", dm_req_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("misal_req_cnt", hs_cnt - h0, 0);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
